// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - layer geometry, address bases and encodings for the 784-64-32-10 MLP sequencer
package nn_pkg;

  localparam int IN_SIZE  = 784;
  localparam int H1_SIZE  = 64;
  localparam int H2_SIZE  = 32;
  localparam int OUT_SIZE = 10;

  localparam int W_AW  = 16;
  localparam int B_AW  = 7;
  localparam int ACC_W = 16;

  // Layer numbers double as the wb_layer encoding.
  localparam logic [1:0] L_H1  = 2'd1;
  localparam logic [1:0] L_H2  = 2'd2;
  localparam logic [1:0] L_OUT = 2'd3;

  localparam logic [1:0] SRC_IN = 2'd0;
  localparam logic [1:0] SRC_H1 = 2'd1;
  localparam logic [1:0] SRC_H2 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  function automatic logic [9:0] last_k_of(input logic [1:0] layer);
    case (layer)
      L_H1:    return 10'(IN_SIZE - 1);
      L_H2:    return 10'(H1_SIZE - 1);
      default: return 10'(H2_SIZE - 1);
    endcase
  endfunction

  function automatic logic [5:0] last_neuron_of(input logic [1:0] layer);
    case (layer)
      L_H1:    return 6'(H1_SIZE - 1);
      L_H2:    return 6'(H2_SIZE - 1);
      default: return 6'(OUT_SIZE - 1);
    endcase
  endfunction

  function automatic logic [W_AW-1:0] w_base_of(input logic [1:0] layer);
    case (layer)
      L_H2:    return W_AW'(IN_SIZE * H1_SIZE);
      L_OUT:   return W_AW'(IN_SIZE * H1_SIZE + H1_SIZE * H2_SIZE);
      default: return '0;
    endcase
  endfunction

  function automatic logic [B_AW-1:0] b_base_of(input logic [1:0] layer);
    case (layer)
      L_H2:    return B_AW'(H1_SIZE);
      L_OUT:   return B_AW'(H1_SIZE + H2_SIZE);
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] act_src_of(input logic [1:0] layer);
    case (layer)
      L_H1:    return SRC_IN;
      L_H2:    return SRC_H1;
      default: return SRC_H2;
    endcase
  endfunction

endpackage

// File: rtl/nn_argmax_tracker.sv
// rtl/nn_argmax_tracker.sv - running signed ArgMax over output-layer writebacks
module nn_argmax_tracker
  import nn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid,
  input  logic [3:0]       idx,
  input  logic [ACC_W-1:0] value,
  output logic [3:0]       best_idx
);

  logic [ACC_W-1:0] best;

  // Index 0 always loads so no sentinel is needed; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
    end else if (clr) begin
      best     <= '0;
      best_idx <= '0;
    end else if (valid && (idx == 4'd0 || $signed(value) > $signed(best))) begin
      best     <= value;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - walks every neuron of the MLP through the shared MAC and reports ArgMax
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       prediction,
  output logic [W_AW-1:0]  w_addr,
  output logic [B_AW-1:0]  b_addr,
  output logic             rd_en,
  output logic [1:0]       act_src,
  output logic [9:0]       act_addr,
  output logic             acc_clr,
  output logic             mac_en,
  output logic             relu_en,
  output logic             wb_en,
  output logic [1:0]       wb_layer,
  output logic [5:0]       wb_addr,
  input  logic [ACC_W-1:0] acc_value
);

  state_t           state, state_nxt;
  logic [1:0]       layer;
  logic [5:0]       neuron;
  logic [9:0]       k;
  logic [3:0]       drain_cnt;
  logic [W_AW-1:0]  w_ptr;
  logic [3:0]       pred_q;
  logic [3:0]       best_idx;
  logic             bias_issue, mac_issue;
  logic             last_neuron;
  logic [RD_LAT-1:0] bias_sr, mac_sr;

  assign last_neuron = (neuron == last_neuron_of(layer));

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    b_addr     = '0;
    w_addr     = '0;
    act_addr   = '0;
    act_src    = '0;
    relu_en    = 1'b0;
    wb_en      = 1'b0;
    wb_layer   = '0;
    wb_addr    = '0;
    bias_issue = 1'b0;
    mac_issue  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_BIAS;
      S_BIAS: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        bias_issue = 1'b1;
        b_addr     = b_base_of(layer) + B_AW'(neuron);
        state_nxt  = S_MAC;
      end
      S_MAC: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        mac_issue = 1'b1;
        w_addr    = w_ptr;
        act_addr  = k;
        act_src   = act_src_of(layer);
        if (k == last_k_of(layer)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 4'(RD_LAT - 1)) state_nxt = S_WB;
      end
      S_WB: begin
        busy      = 1'b1;
        wb_en     = 1'b1;
        wb_layer  = layer;
        wb_addr   = neuron;
        relu_en   = (layer != L_OUT);
        state_nxt = (last_neuron && layer == L_OUT) ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      layer     <= '0;
      neuron    <= '0;
      k         <= '0;
      drain_cnt <= '0;
      w_ptr     <= '0;
      pred_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          layer  <= L_H1;
          neuron <= '0;
          w_ptr  <= w_base_of(L_H1);
        end
        S_BIAS: k <= '0;
        S_MAC: begin
          k         <= k + 10'd1;
          w_ptr     <= w_ptr + 1'b1;
          drain_cnt <= '0;
        end
        S_DRAIN: drain_cnt <= drain_cnt + 4'd1;
        S_WB: if (last_neuron) begin
          layer  <= layer + 2'd1;
          neuron <= '0;
          w_ptr  <= w_base_of(layer + 2'd1);
        end else begin
          neuron <= neuron + 6'd1;
        end
        S_DONE: pred_q <= best_idx;
        default: ;
      endcase
    end
  end

  // Issue flags ride a RD_LAT-deep pipe so acc_clr/mac_en line up with the returning read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_sr <= '0;
      mac_sr  <= '0;
    end else begin
      bias_sr[0] <= bias_issue;
      mac_sr[0]  <= mac_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        bias_sr[i] <= bias_sr[i-1];
        mac_sr[i]  <= mac_sr[i-1];
      end
    end
  end

  assign acc_clr = bias_sr[RD_LAT-1];
  assign mac_en  = mac_sr[RD_LAT-1];

  nn_argmax_tracker u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_IDLE && start),
    .valid    (state == S_WB && layer == L_OUT),
    .idx      (neuron[3:0]),
    .value    (acc_value),
    .best_idx (best_idx)
  );

  // The final compare lands on the edge into DONE, so forward it during the done pulse.
  assign prediction = (state == S_DONE) ? best_idx : pred_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - directed bench for nn_layer_sequencer (RD_LAT 1 and 2 instances)
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, rst2, start2;
  logic        busy, done, rd_en, acc_clr, mac_en, relu_en, wb_en;
  logic [3:0]  prediction;
  logic [15:0] w_addr, acc_value;
  logic [6:0]  b_addr;
  logic [1:0]  act_src, wb_layer;
  logic [9:0]  act_addr;
  logic [5:0]  wb_addr;
  logic        busy2, done2, rd_en2, acc_clr2, mac_en2, relu_en2, wb_en2;
  logic [3:0]  prediction2;
  logic [15:0] w_addr2, acc_value2;
  logic [6:0]  b_addr2;
  logic [1:0]  act_src2, wb_layer2;
  logic [9:0]  act_addr2;
  logic [5:0]  wb_addr2;

  int errors = 0;
  int checks = 0;
  int tbl1 [10] = '{5, -3, 9, 9, 2, 0, -7, 1, 8, 4};

  nn_layer_sequencer #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .prediction(prediction),
    .w_addr(w_addr), .b_addr(b_addr), .rd_en(rd_en), .act_src(act_src), .act_addr(act_addr),
    .acc_clr(acc_clr), .mac_en(mac_en), .relu_en(relu_en), .wb_en(wb_en), .wb_layer(wb_layer),
    .wb_addr(wb_addr), .acc_value(acc_value)
  );

  nn_layer_sequencer #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2), .prediction(prediction2),
    .w_addr(w_addr2), .b_addr(b_addr2), .rd_en(rd_en2), .act_src(act_src2), .act_addr(act_addr2),
    .acc_clr(acc_clr2), .mac_en(mac_en2), .relu_en(relu_en2), .wb_en(wb_en2), .wb_layer(wb_layer2),
    .wb_addr(wb_addr2), .acc_value(acc_value2)
  );

  // Accumulator stubs: zero for hidden layers, fixed score tables for the output layer.
  always_comb acc_value  = (wb_en && wb_layer == 2'd3) ? 16'(tbl1[wb_addr[3:0]]) : 16'd0;
  always_comb acc_value2 = (wb_en2 && wb_layer2 == 2'd3) ? 16'(-100 + int'(wb_addr2)) : 16'd0;

  wire [53:0] all1 = {busy, done, prediction, w_addr, b_addr, rd_en, act_src, act_addr,
                      acc_clr, mac_en, relu_en, wb_en, wb_layer, wb_addr};
  wire [53:0] all2 = {busy2, done2, prediction2, w_addr2, b_addr2, rd_en2, act_src2, act_addr2,
                      acc_clr2, mac_en2, relu_en2, wb_en2, wb_layer2, wb_addr2};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int wbc1 [4];
  int wbc2 [4];
  int rd_cnt1, max_w1, max_b1, overlap, done_cyc1, done_cyc2, ndone1, first_wb2;
  logic [3:0] pred_done1, pred_done2;
  logic       busy_done1;

  initial begin
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    wbc1 = '{default: 0}; wbc2 = '{default: 0};
    rd_cnt1 = 0; max_w1 = 0; max_b1 = 0; overlap = 0;
    done_cyc1 = 0; done_cyc2 = 0; ndone1 = 0; first_wb2 = 0;
    pred_done1 = '0; pred_done2 = '0; busy_done1 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all1), 64'd0);
    check("reset_outputs_rdlat2", 64'(all2), 64'd0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // First neuron of layer 1: bias issue, 784 weight issues, drain, writeback.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 900; c++) begin
      if (c == 1)
        check("bias_issue", {rd_en, b_addr, busy, acc_clr, mac_en}, {1'b1, 7'd0, 1'b1, 1'b0, 1'b0});
      if (c >= 2 && c <= 785)
        check("mac_issue", {rd_en, act_src, w_addr, act_addr}, {1'b1, 2'd0, 16'(c - 2), 10'(c - 2)});
      if (c == 2) check("acc_clr_lag1", {acc_clr, mac_en}, 2'b10);
      if (c == 3) check("mac_en_lag1", {acc_clr, mac_en}, 2'b01);
      if (c == 786) check("drain", {rd_en, mac_en, wb_en}, 3'b010);
      if (c == 787)
        check("first_wb", {wb_en, wb_layer, wb_addr, relu_en, mac_en, acc_clr},
              {1'b1, 2'd1, 6'd0, 1'b1, 1'b0, 1'b0});
      if (c == 788) check("second_bias", {rd_en, b_addr, acc_clr}, {1'b1, 7'd1, 1'b0});
      if (c == 789) check("second_mac", {rd_en, w_addr}, {1'b1, 16'd784});
      @(negedge clk);
    end

    // Asynchronous reset mid-run, then full runs on both instances in parallel.
    check("busy_before_rst", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", 64'(all1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    for (int c = 1; c <= 53000; c++) begin
      if (c < 52863) begin
        if (rd_en) begin
          rd_cnt1++;
          if (int'(w_addr) > max_w1) max_w1 = int'(w_addr);
          if (int'(b_addr) > max_b1) max_b1 = int'(b_addr);
        end
        if (wb_en) wbc1[wb_layer]++;
      end
      if (wb_en2) begin
        wbc2[wb_layer2]++;
        if (first_wb2 == 0) first_wb2 = c;
      end
      if (wb_en && (mac_en || acc_clr)) overlap++;
      if (wb_en2 && (mac_en2 || acc_clr2)) overlap++;
      if (done) begin
        ndone1++;
        if (done_cyc1 == 0) begin
          done_cyc1 = c; pred_done1 = prediction; busy_done1 = busy;
        end
      end
      if (done2 && done_cyc2 == 0) begin
        done_cyc2 = c; pred_done2 = prediction2;
      end
      if (c == 2) check("rdlat2_mac0", {acc_clr2, mac_en2, rd_en2, w_addr2}, {3'b001, 16'd0});
      if (c == 3) check("rdlat2_acc_clr", {acc_clr2, mac_en2, w_addr2}, {2'b10, 16'd1});
      if (c == 4) check("rdlat2_mac_en", {acc_clr2, mac_en2}, 2'b01);
      if (c == 52862) check("pre_done", {busy, done, prediction}, {1'b1, 1'b0, 4'd0});
      if (c == 52864) check("idle_after_done", {busy, done, rd_en, prediction}, {3'b000, 4'd2});
      if (c == 52865) check("restart_bias", {busy, rd_en, b_addr}, {1'b1, 1'b1, 7'd0});
      start = (c == 51000) || (c >= 52860 && c <= 52864);
      @(negedge clk);
    end
    start = 1'b0;

    check("done_cycle", 64'(done_cyc1), 64'd52863);
    check("done_pulses", 64'(ndone1), 64'd1);
    check("busy_at_done", 64'(busy_done1), 64'd0);
    check("prediction_at_done", 64'(pred_done1), 64'd2);
    check("wb_layer1", 64'(wbc1[1]), 64'd64);
    check("wb_layer2", 64'(wbc1[2]), 64'd32);
    check("wb_layer3", 64'(wbc1[3]), 64'd10);
    check("max_w_addr", 64'(max_w1), 64'd52543);
    check("max_b_addr", 64'(max_b1), 64'd105);
    check("rd_issues", 64'(rd_cnt1), 64'd52650);
    check("wb_mac_overlap", 64'(overlap), 64'd0);
    check("prediction_held", {busy, prediction}, {1'b1, 4'd2});
    check("rdlat2_first_wb", 64'(first_wb2), 64'd788);
    check("rdlat2_done_cycle", 64'(done_cyc2), 64'd52969);
    check("rdlat2_wb_total", 64'(wbc2[1] + wbc2[2] + wbc2[3]), 64'd106);
    check("rdlat2_prediction_at_done", 64'(pred_done2), 64'd9);
    check("rdlat2_prediction_held", {busy2, prediction2}, {1'b0, 4'd9});

    // Reset during the second run discards the held prediction too.
    #2 rst = 1'b1;
    #1 check("rst_clears_prediction", 64'(all1), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
